// File: rtl/axi_lite_mem_slave_if.sv
// ---------------------------------------------------------------------------
// axi_lite_mem_slave_if
// AXI4-Lite bus bundle between the merged IFU/LSU master and the memory
// responder. Clock and reset are not part of the bundle.
//   AR : araddr, arvalid (master) / arready (slave)
//   R  : rdata, rresp, rvalid (slave) / rready (master)
//   AW : awaddr, awvalid (master) / awready (slave)
//   W  : wdata, wstrb, wvalid (master) / wready (slave)
//   B  : bresp, bvalid (slave) / bready (master)
// ---------------------------------------------------------------------------
interface axi_lite_mem_slave_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_mem_slave
// AXI4-Lite responder with independent read and write FSMs and programmable
// response latency. Backing storage lives outside the block and is reached
// through a word-aligned access port that stands in for n_pmem_read /
// n_pmem_write: a strobe is raised on the exact edge at which the responder
// samples or commits, so read data is taken before any write committing on
// the same edge lands (read-before-write).
// Ports:
//   clk            : single clock, rising edge
//   rst            : asynchronous active-low reset
//   bus            : AXI4-Lite slave modport
//   pmem_ren_o     : read call on this edge (valid address only)
//   pmem_raddr_o   : word-aligned read address
//   pmem_rdata_i   : read data returned by storage (combinational)
//   pmem_wen_o     : write call on this edge (valid address only)
//   pmem_waddr_o   : word-aligned write address
//   pmem_wdata_o   : write data
//   pmem_wmask_o   : write byte mask (bits [3:0] meaningful)
// ---------------------------------------------------------------------------
module axi_lite_mem_slave #(
    parameter logic [31:0] BASE        = 32'h8000_0000,
    parameter logic [31:0] SIZE        = 32'h0800_0000,
    parameter int unsigned READ_DELAY  = 1,
    parameter int unsigned WRITE_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    axi_lite_mem_slave_if.slave bus,
    output logic        pmem_ren_o,
    output logic [31:0] pmem_raddr_o,
    input  logic [31:0] pmem_rdata_i,
    output logic        pmem_wen_o,
    output logic [31:0] pmem_waddr_o,
    output logic [31:0] pmem_wdata_o,
    output logic [7:0]  pmem_wmask_o
);
    localparam logic [3:0] RD     = 4'(READ_DELAY);
    localparam logic [3:0] WD     = 4'(WRITE_DELAY);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_t;

    // Unsigned 33-bit range check so BASE+SIZE may reach 2^32 without wrapping.
    function automatic logic addr_ok(input logic [31:0] a);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, BASE};
        hi = {1'b0, BASE} + {1'b0, SIZE};
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

    r_state_t    r_state_q, r_state_d;
    w_state_t    w_state_q, w_state_d;
    logic        live_q;
    logic [3:0]  rcnt_q, rcnt_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] raddr_q, raddr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic        aw_got_q, aw_got_d;
    logic        w_got_q, w_got_d;
    logic [1:0]  bresp_q, bresp_d;

    logic        ar_hs_s, aw_hs_s, w_hs_s;
    logic        r_enter_s, w_commit_s;
    logic [31:0] rd_addr_s, wr_addr_s, wr_data_s;
    logic [7:0]  wr_strb_s;

    assign bus.arready = live_q & (r_state_q == R_IDLE);
    assign bus.awready = live_q & (w_state_q == W_IDLE) & ~aw_got_q;
    assign bus.wready  = live_q & (w_state_q == W_IDLE) & ~w_got_q;
    assign bus.rvalid  = (r_state_q == R_RESP);
    assign bus.bvalid  = (w_state_q == W_RESP);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.bresp   = bresp_q;

    assign ar_hs_s = bus.arvalid & bus.arready;
    assign aw_hs_s = bus.awvalid & bus.awready;
    assign w_hs_s  = bus.wvalid & bus.wready;

    // With zero delay the sample happens on the handshake edge itself, so the
    // live bus value is used before it has been latched.
    assign rd_addr_s = (r_state_q == R_IDLE) ? bus.araddr : raddr_q;
    assign wr_addr_s = aw_got_q ? awaddr_q : bus.awaddr;
    assign wr_data_s = w_got_q ? wdata_q : bus.wdata;
    assign wr_strb_s = w_got_q ? wstrb_q : bus.wstrb;

    assign pmem_ren_o   = r_enter_s & addr_ok(rd_addr_s);
    assign pmem_raddr_o = rd_addr_s & 32'hFFFF_FFFC;
    assign pmem_wen_o   = w_commit_s & addr_ok(wr_addr_s);
    assign pmem_waddr_o = wr_addr_s & 32'hFFFF_FFFC;
    assign pmem_wdata_o = wr_data_s;
    assign pmem_wmask_o = wr_strb_s;

    // Read FSM next state: accept AR, count down the delay, hold response.
    always_comb begin
        r_state_d = r_state_q;
        rcnt_d    = rcnt_q;
        raddr_d   = raddr_q;
        r_enter_s = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    raddr_d = bus.araddr;
                    rcnt_d  = RD;
                    if (RD == 4'd0) begin
                        r_enter_s = 1'b1;
                        r_state_d = R_RESP;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_WAIT: begin
                if (rcnt_q == 4'd1) begin
                    r_enter_s = 1'b1;
                    r_state_d = R_RESP;
                end else begin
                    rcnt_d = rcnt_q - 4'd1;
                end
            end
            R_RESP: begin
                if (bus.rready) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = R_RESP;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read data/response capture on the edge entering R_RESP.
    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (r_enter_s) begin
            if (addr_ok(rd_addr_s)) begin
                rdata_d = pmem_rdata_i;
                rresp_d = OKAY;
            end else begin
                rdata_d = 32'd0;
                rresp_d = DECERR;
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Write FSM next state: gather AW and W in any order, delay, respond.
    always_comb begin
        w_state_d  = w_state_q;
        wcnt_d     = wcnt_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        bresp_d    = bresp_q;
        w_commit_s = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s) begin
                    aw_got_d = 1'b1;
                    awaddr_d = bus.awaddr;
                end else begin
                    aw_got_d = aw_got_q;
                end
                if (w_hs_s) begin
                    w_got_d = 1'b1;
                    wdata_d = bus.wdata;
                    wstrb_d = bus.wstrb;
                end else begin
                    w_got_d = w_got_q;
                end
                if (aw_got_d && w_got_d) begin
                    wcnt_d = WD;
                    if (WD == 4'd0) begin
                        w_commit_s = 1'b1;
                        w_state_d  = W_RESP;
                    end else begin
                        w_state_d = W_WAIT;
                    end
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_WAIT: begin
                if (wcnt_q == 4'd1) begin
                    w_commit_s = 1'b1;
                    w_state_d  = W_RESP;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (w_commit_s) begin
            bresp_d = addr_ok(wr_addr_s) ? OKAY : DECERR;
        end else begin
            bresp_d = bresp_q;
        end
    end

    // State registers; reset drops any in-flight transaction silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q    <= 1'b0;
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
            rcnt_q    <= 4'd0;
            wcnt_q    <= 4'd0;
            raddr_q   <= 32'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'b00;
            awaddr_q  <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 8'd0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            live_q    <= 1'b1;
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            rcnt_q    <= rcnt_d;
            wcnt_q    <= wcnt_d;
            raddr_q   <= raddr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            bresp_q   <= bresp_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_mem_slave
// Self-checking bench for axi_lite_mem_slave (READ_DELAY=1, WRITE_DELAY=2).
// Storage behind the pmem port is a 256-word array indexed by addr[9:2];
// expected data comes from a word-keyed associative model plus constants.
// ---------------------------------------------------------------------------
module tb_axi_lite_mem_slave;
    localparam int RDLY = 1;
    localparam int WDLY = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;

    logic        pmem_ren, pmem_wen;
    logic [31:0] pmem_raddr, pmem_rdata, pmem_waddr, pmem_wdata;
    logic [7:0]  pmem_wmask;

    axi_lite_mem_slave_if bus ();

    axi_lite_mem_slave #(
        .BASE(32'h8000_0000), .SIZE(32'h0800_0000),
        .READ_DELAY(RDLY), .WRITE_DELAY(WDLY)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .pmem_ren_o(pmem_ren), .pmem_raddr_o(pmem_raddr), .pmem_rdata_i(pmem_rdata),
        .pmem_wen_o(pmem_wen), .pmem_waddr_o(pmem_waddr), .pmem_wdata_o(pmem_wdata),
        .pmem_wmask_o(pmem_wmask)
    );

    always #5 clk = ~clk;

    // Backing storage and call counters.
    logic [31:0] mem [256];
    int rd_calls;
    int wr_calls;
    assign pmem_rdata = mem[pmem_raddr[9:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            rd_calls <= 0;
            wr_calls <= 0;
        end else begin
            if (pmem_ren) rd_calls <= rd_calls + 1;
            if (pmem_wen) begin
                wr_calls <= wr_calls + 1;
                for (int b = 0; b < 4; b++)
                    if (pmem_wmask[b]) mem[pmem_waddr[9:2]][8*b +: 8] <= pmem_wdata[8*b +: 8];
            end
        end
    end

    // Reference model: word address -> contents, default zero.
    logic [31:0] model_mem [int unsigned];

    function automatic bit in_range(input logic [31:0] a);
        longint unsigned x;
        x = longint'(a);
        return (x >= 64'h8000_0000) && (x < 64'h8000_0000 + 64'h0800_0000);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (!in_range(a)) return 32'd0;
        return model_mem.exists(k) ? model_mem[k] : 32'd0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
        logic [31:0] w;
        if (in_range(a)) begin
            w = model_read(a);
            for (int b = 0; b < 4; b++)
                if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            model_mem[a >> 2] = w;
        end
    endtask

    int total  = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // One read: optional start delay, optional rready hold while rvalid is up.
    task automatic axi_read(input logic [31:0] a, input int pre, input int hold,
                            output logic [31:0] d, output logic [1:0] r, output int lat,
                            output bit blk_ok, output bit stab_ok);
        int k;
        blk_ok = 1'b1;
        stab_ok = 1'b1;
        repeat (pre) @(negedge clk);
        @(negedge clk);
        bus.araddr = a;
        bus.arvalid = 1'b1;
        k = 0;
        while (!bus.arready && k < 60) begin
            @(negedge clk);
            k++;
        end
        lat = 0;
        do begin
            @(negedge clk);
            bus.arvalid = 1'b0;
            lat++;
            if (bus.arready) blk_ok = 1'b0;
        end while (!bus.rvalid && lat < 60);
        d = bus.rdata;
        r = bus.rresp;
        repeat (hold) begin
            @(negedge clk);
            if (!bus.rvalid || bus.rdata !== d || bus.rresp !== r) stab_ok = 1'b0;
            if (bus.arready) blk_ok = 1'b0;
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    // One write: AW offered from cycle aw_at, W from cycle w_at.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                             input int aw_at, input int w_at, input int hold,
                             output logic [1:0] resp, output int lat,
                             output bit blk_ok, output bit stab_ok);
        bit aw_done, w_done, aw_hs, w_hs;
        int k;
        aw_done = 1'b0; w_done = 1'b0;
        blk_ok = 1'b1; stab_ok = 1'b1;
        k = 0;
        while (!(aw_done && w_done) && k < 60) begin
            @(negedge clk);
            if (aw_done) bus.awvalid = 1'b0;
            else begin bus.awvalid = (k >= aw_at); bus.awaddr = a; end
            if (w_done) bus.wvalid = 1'b0;
            else begin bus.wvalid = (k >= w_at); bus.wdata = d; bus.wstrb = s; end
            if (w_done && bus.wready) blk_ok = 1'b0;
            if (aw_done && bus.awready) blk_ok = 1'b0;
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(posedge clk);
            if (aw_hs) aw_done = 1'b1;
            if (w_hs) w_done = 1'b1;
            k++;
        end
        lat = 0;
        do begin
            @(negedge clk);
            bus.awvalid = 1'b0;
            bus.wvalid = 1'b0;
            lat++;
            if (bus.awready || bus.wready) blk_ok = 1'b0;
        end while (!bus.bvalid && lat < 60);
        resp = bus.bresp;
        repeat (hold) begin
            @(negedge clk);
            if (!bus.bvalid || bus.bresp !== resp) stab_ok = 1'b0;
            if (bus.awready || bus.wready) blk_ok = 1'b0;
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                            input int aw_at, input int w_at, input int hold,
                            output logic [1:0] resp, output int lat,
                            output bit blk_ok, output bit stab_ok);
        axi_write(a, d, s, aw_at, w_at, hold, resp, lat, blk_ok, stab_ok);
        model_write(a, d, s);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  strb;
        logic [1:0]  exp_bresp;
        logic [1:0]  exp_rresp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [31:0] d;
        logic [1:0]  r, br;
        int          lat, wlat, c0;
        bit          blk, stab, wblk, wstab;
        logic [31:0] a, wd;
        logic [7:0]  ws;

        vecs[0] = '{32'h8000_0040, 32'h1234_5678, 8'h0F, 2'b00, 2'b00, 32'h1234_5678};
        vecs[1] = '{32'h8000_0044, 32'hCAFE_F00D, 8'hF0, 2'b00, 2'b00, 32'h0000_0000};
        vecs[2] = '{32'h8000_0048, 32'hA1B2_C3D4, 8'h05, 2'b00, 2'b00, 32'h00B2_00D4};
        vecs[3] = '{32'h8000_004E, 32'h5566_7788, 8'h0C, 2'b00, 2'b00, 32'h5566_0000};
        vecs[4] = '{32'h7FFF_FFFC, 32'h0000_0001, 8'h0F, 2'b11, 2'b11, 32'h0000_0000};
        vecs[5] = '{32'h8800_0000, 32'h0000_0002, 8'h0F, 2'b11, 2'b11, 32'h0000_0000};
        vecs[6] = '{32'h87FF_FFFC, 32'h0BAD_F00D, 8'h0F, 2'b00, 2'b00, 32'h0BAD_F00D};

        bus.araddr = 32'd0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = 32'd0; bus.awvalid = 1'b0; bus.wdata = 32'd0;
        bus.wstrb = 8'd0; bus.wvalid = 1'b0; bus.bready = 1'b0;

        // Reset state
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_arready", 32'(bus.arready), 32'd0);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_wready", 32'(bus.wready), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_rresp", 32'(bus.rresp), 32'd0);
        chk("rst_bresp", 32'(bus.bresp), 32'd0);
        rst = 1'b1;
        mem_init = 1'b0;
        #1 chk("live_delay_arready", 32'(bus.arready), 32'd0);
        @(negedge clk);
        chk("live_arready", 32'(bus.arready), 32'd1);

        // Basic read with delay 1
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 0, 0, br, wlat, wblk, wstab);
        axi_read(32'h8000_0012, 0, 0, d, r, lat, blk, stab);
        chk("rd_lat", 32'(lat), 32'(RDLY + 1));
        chk("rd_data", d, 32'hDEAD_BEEF);
        chk("rd_resp", 32'(r), 32'd0);
        chk("rd_arready_low", 32'(blk), 32'd1);

        // DECERR paths: no storage calls
        c0 = rd_calls;
        axi_read(32'h0000_0100, 0, 0, d, r, lat, blk, stab);
        chk("oob_rresp", 32'(r), 32'd3);
        chk("oob_rdata", d, 32'd0);
        chk("oob_no_rd_call", 32'(rd_calls - c0), 32'd0);
        c0 = wr_calls;
        do_write(32'h9000_0000, 32'h5A5A_5A5A, 8'h0F, 0, 0, 0, br, wlat, wblk, wstab);
        chk("oob_bresp", 32'(br), 32'd3);
        chk("oob_no_wr_call", 32'(wr_calls - c0), 32'd0);
        axi_read(32'h8000_0000, 0, 0, d, r, lat, blk, stab);
        chk("oob_mem_unchanged", d, 32'd0);

        // W two cycles before AW with partial strobe
        do_write(32'h8000_0020, 32'hAAAA_AAAA, 8'h0F, 0, 0, 0, br, wlat, wblk, wstab);
        do_write(32'h8000_0020, 32'h1122_3344, 8'h03, 2, 0, 0, br, wlat, wblk, wstab);
        chk("wfirst_wready_low", 32'(wblk), 32'd1);
        chk("wfirst_lat", 32'(wlat), 32'(WDLY + 1));
        chk("wfirst_bresp", 32'(br), 32'd0);
        axi_read(32'h8000_0020, 0, 0, d, r, lat, blk, stab);
        chk("wfirst_readback", d, 32'hAAAA_3344);

        // Backpressure on R and B
        axi_read(32'h8000_0010, 0, 5, d, r, lat, blk, stab);
        chk("rhold_stable", 32'(stab), 32'd1);
        chk("rhold_no_ar", 32'(blk), 32'd1);
        chk("rhold_data", d, 32'hDEAD_BEEF);
        do_write(32'h8000_0024, 32'h0000_00FF, 8'h01, 0, 1, 5, br, wlat, wblk, wstab);
        chk("bhold_stable", 32'(wstab), 32'd1);
        chk("bhold_no_aw_w", 32'(wblk), 32'd1);

        // Read sample and write commit on the same edge
        do_write(32'h8000_0030, 32'h0000_0001, 8'h0F, 0, 0, 0, br, wlat, wblk, wstab);
        fork
            do_write(32'h8000_0030, 32'h0000_0002, 8'h0F, 0, 0, 0, br, wlat, wblk, wstab);
            axi_read(32'h8000_0030, 1, 0, d, r, lat, blk, stab);
        join
        chk("same_edge_old", d, 32'h0000_0001);
        axi_read(32'h8000_0030, 0, 0, d, r, lat, blk, stab);
        chk("same_edge_new", d, 32'h0000_0002);

        // Table-driven write/readback vectors
        for (int i = 0; i < 7; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 2, (i + 1) % 3, 0,
                     br, wlat, wblk, wstab);
            chk($sformatf("vec%0d_bresp", i), 32'(br), 32'(vecs[i].exp_bresp));
            chk($sformatf("vec%0d_wlat", i), 32'(wlat), 32'(WDLY + 1));
            axi_read(vecs[i].addr, 0, 0, d, r, lat, blk, stab);
            chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_rresp));
            chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) a = 32'h9000_0000 | ($urandom & 32'h0000_0FFF);
            else a = 32'h8000_0100 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                ws = 8'($urandom_range(0, 255));
                do_write(a, wd, ws, $urandom_range(0, 2), $urandom_range(0, 2), 0,
                         br, wlat, wblk, wstab);
                chk($sformatf("rnd%0d_bresp", i), 32'(br), in_range(a) ? 32'd0 : 32'd3);
                chk($sformatf("rnd%0d_wlat", i), 32'(wlat), 32'(WDLY + 1));
            end else begin
                axi_read(a, 0, 0, d, r, lat, blk, stab);
                chk($sformatf("rnd%0d_rresp", i), 32'(r), in_range(a) ? 32'd0 : 32'd3);
                chk($sformatf("rnd%0d_rdata", i), d, model_read(a));
                chk($sformatf("rnd%0d_rlat", i), 32'(lat), 32'(RDLY + 1));
            end
        end

        // Reset asserted while a write waits: write must be discarded
        @(negedge clk);
        bus.awaddr = 32'h8000_0050; bus.awvalid = 1'b1;
        bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 8'h0F; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        c0 = wr_calls;
        rst = 1'b0;
        #1;
        chk("mid_rst_arready", 32'(bus.arready), 32'd0);
        chk("mid_rst_awready", 32'(bus.awready), 32'd0);
        chk("mid_rst_wready", 32'(bus.wready), 32'd0);
        chk("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("mid_rst_rdata", bus.rdata, 32'd0);
        chk("mid_rst_rresp", 32'(bus.rresp), 32'd0);
        chk("mid_rst_bresp", 32'(bus.bresp), 32'd0);
        repeat (4) @(negedge clk);
        chk("mid_rst_no_wr_call", 32'(wr_calls - c0), 32'd0);
        rst = 1'b1;
        #1 chk("rel_arready_early", 32'(bus.arready), 32'd0);
        @(negedge clk);
        chk("rel_arready", 32'(bus.arready), 32'd1);
        chk("rel_awready", 32'(bus.awready), 32'd1);
        chk("rel_wready", 32'(bus.wready), 32'd1);
        axi_read(32'h8000_0050, 0, 0, d, r, lat, blk, stab);
        chk("mid_rst_mem_unchanged", d, 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
